// File: rtl/irq_ctrl_pkg.sv
// Shared constants for irq_ctrl: states, interrupt codes, CSR addresses.
// Build option: IRQ_PENDING_LATCH_EN latches one-cycle timer pulses.
package irq_ctrl_pkg;

  localparam int INT_W  = 8;
  localparam int HOLD_W = 3;

  localparam logic [INT_W-1:0] INT_NONE   = 8'h00;
  localparam logic [INT_W-1:0] INT_TIMER0 = 8'h01;
  localparam logic [INT_W-1:0] INT_RET    = 8'hff;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_W_MEPC     = 3'd1;
  localparam logic [2:0] S_W_MCAUSE   = 3'd2;
  localparam logic [2:0] S_W_MSTATUS  = 3'd3;
  localparam logic [2:0] S_INT_ASSERT = 3'd4;
  localparam logic [2:0] S_R_MSTATUS  = 3'd5;
  localparam logic [2:0] S_RET_ASSERT = 3'd6;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_enter(
    input logic [31:0] m
  );
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_ret(
    input logic [31:0] m
  );
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_ctrl.sv
// Timer-interrupt entry / mret sequencer writing mepc, mcause, mstatus.
// Build option: IRQ_PENDING_LATCH_EN holds a timer pulse until taken.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic [INT_W-1:0]  int_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic [31:0]       csr_mepc_i,
  input  logic              global_int_en_i,
  output logic              we_o,
  output logic [11:0]       waddr_o,
  output logic [31:0]       data_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [31:0]       int_addr_o,
  output logic              hold_flag_o
);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        timer_req;
  logic        pending;
  logic        accept;

  assign timer_req = (int_i == INT_TIMER0);

`ifdef IRQ_PENDING_LATCH_EN
  logic pend_q, pend_d;

  always_comb begin
    pend_d = (pend_q & (state_q != S_INT_ASSERT))
           | timer_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= 1'b0;
    else      pend_q <= pend_d;
  end

  assign pending = pend_q | timer_req;
`else
  assign pending = timer_req;
`endif

  assign accept = pending & global_int_en_i
                & (hold_flag_i == HOLD_NONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        // mret wins over a simultaneous interrupt
        if (inst_i == INST_MRET) begin
          state_d = S_R_MSTATUS;
        end else if (accept) begin
          state_d = S_W_MEPC;
          addr_d  = jump_flag_i ? jump_addr_i
                                : inst_addr_i;
        end
      end
      S_W_MEPC:     state_d = S_W_MCAUSE;
      S_W_MCAUSE:   state_d = S_W_MSTATUS;
      S_W_MSTATUS:  state_d = S_INT_ASSERT;
      S_INT_ASSERT: state_d = S_IDLE;
      S_R_MSTATUS:  state_d = S_RET_ASSERT;
      S_RET_ASSERT: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    we_o       = 1'b0;
    waddr_o    = '0;
    data_o     = '0;
    int_flag_o = INT_NONE;
    int_addr_o = '0;
    unique case (state_q)
      S_W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = addr_q;
      end
      S_W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = MCAUSE_TIMER;
      end
      S_W_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_enter(csr_mstatus_i);
      end
      S_INT_ASSERT: int_flag_o = INT_TIMER0;
      S_R_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_ret(csr_mstatus_i);
      end
      S_RET_ASSERT: begin
        int_flag_o = INT_RET;
        int_addr_o = csr_mepc_i;
      end
      default: ;
    endcase
  end

  assign hold_flag_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: frame-queue reference model plus directed
// literal checks and randomized traffic.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       inst_i, inst_addr_i, jump_addr_i;
  logic              jump_flag_i;
  logic [HOLD_W-1:0] hold_flag_i;
  logic [INT_W-1:0]  int_i;
  logic [31:0]       csr_mstatus_i, csr_mepc_i;
  logic              global_int_en_i;
  logic              we_o, hold_flag_o;
  logic [11:0]       waddr_o;
  logic [31:0]       data_o, int_addr_o;
  logic [INT_W-1:0]  int_flag_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  irq_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .int_i(int_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mepc_i(csr_mepc_i),
    .global_int_en_i(global_int_en_i),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_flag_o(int_flag_o), .int_addr_o(int_addr_o),
    .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference: each accepted request becomes a script of output
  // frames, one frame per cycle, consumed front to back.
  localparam int K_MEPC = 0, K_MCAUSE = 1, K_MST = 2;
  localparam int K_INT = 3, K_RMST = 4, K_RET = 5;
  typedef struct { int k; logic [31:0] a; } fr_t;
  fr_t q[$];
  bit  pend_m = 0;

  initial begin
    forever begin
      bit live, clr, pnd;
      logic [31:0] ra;
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        pend_m = 0;
      end else begin
        live = (int_i == INT_TIMER0);
        clr  = 0;
`ifdef IRQ_PENDING_LATCH_EN
        pnd = live || pend_m;
`else
        pnd = live;
`endif
        if (q.size() != 0) begin
          clr = (q[0].k == K_INT);
          void'(q.pop_front());
        end else if (inst_i == INST_MRET) begin
          q.push_back('{K_RMST, 32'h0});
          q.push_back('{K_RET, 32'h0});
        end else if (pnd && global_int_en_i &&
                     hold_flag_i == HOLD_NONE) begin
          ra = jump_flag_i ? jump_addr_i : inst_addr_i;
          q.push_back('{K_MEPC, ra});
          q.push_back('{K_MCAUSE, 32'h0});
          q.push_back('{K_MST, 32'h0});
          q.push_back('{K_INT, 32'h0});
        end
        pend_m = (pend_m && !clr) || live;
      end
    end
  end

  // Compare process: every negedge, DUT vs the model's current frame.
  initial begin
    forever begin
      logic        e_we, e_h;
      logic [11:0] e_wa;
      logic [31:0] e_d, e_ia, m;
      logic [INT_W-1:0] e_if;
      @(negedge clk);
      e_we = 0; e_h = 0; e_wa = 0;
      e_d = 0; e_ia = 0; e_if = INT_NONE;
      m = csr_mstatus_i;
      if (q.size() != 0) begin
        e_h = 1;
        case (q[0].k)
          K_MEPC: begin
            e_we = 1; e_wa = 12'h341; e_d = q[0].a;
          end
          K_MCAUSE: begin
            e_we = 1; e_wa = 12'h342; e_d = 32'h8000_0007;
          end
          K_MST: begin
            e_we = 1; e_wa = 12'h300;
            e_d = (m & ~32'h88) | ({31'h0, m[3]} << 7);
          end
          K_INT: e_if = 8'h01;
          K_RMST: begin
            e_we = 1; e_wa = 12'h300;
            e_d = (m & ~32'h88) | ({31'h0, m[7]} << 3)
                | 32'h80;
          end
          default: begin
            e_if = 8'hff; e_ia = csr_mepc_i;
          end
        endcase
      end
      chk("m_we", {31'h0, we_o}, {31'h0, e_we});
      chk("m_waddr", {20'h0, waddr_o}, {20'h0, e_wa});
      chk("m_data", data_o, e_d);
      chk("m_intflag", {24'h0, int_flag_o}, {24'h0, e_if});
      chk("m_intaddr", int_addr_o, e_ia);
      chk("m_hold", {31'h0, hold_flag_o}, {31'h0, e_h});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    inst_i = NOP; int_i = INT_NONE; hold_flag_i = HOLD_NONE;
    global_int_en_i = 0; jump_flag_i = 0;
    repeat (6) tick();
  endtask

  task automatic take_int(input logic jf,
                          input logic [31:0] ja,
                          input logic [31:0] exp_mepc);
    inst_addr_i = 32'h100; jump_flag_i = jf; jump_addr_i = ja;
    csr_mstatus_i = 32'h8; global_int_en_i = 1;
    int_i = INT_TIMER0;
    tick();
    int_i = INT_NONE; jump_flag_i = 0;
    @(negedge clk);
    chk("d_mepc_addr", {20'h0, waddr_o}, 32'h341);
    chk("d_mepc_data", data_o, exp_mepc);
    tick(); @(negedge clk);
    chk("d_mcause", data_o, 32'h8000_0007);
    tick(); @(negedge clk);
    chk("d_mst_enter", data_o, 32'h80);
    tick(); @(negedge clk);
    chk("d_timer0", {24'h0, int_flag_o}, 32'h1);
    tick(); @(negedge clk);
    chk("d_after_int", {31'h0, hold_flag_o}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_we;
    rst = 0;
    inst_i = NOP; inst_addr_i = 0; jump_flag_i = 0; jump_addr_i = 0;
    hold_flag_i = HOLD_NONE; int_i = INT_NONE;
    csr_mstatus_i = 0; csr_mepc_i = 0; global_int_en_i = 0;
    int_i = INT_TIMER0; global_int_en_i = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_hold", {31'h0, hold_flag_o}, 32'h0);
    tick();
    rst = 1;
    quiet();

    take_int(1'b0, 32'h0, 32'h100);
    quiet();
    take_int(1'b1, 32'h200, 32'h200);
    quiet();

    inst_i = INST_MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    tick();
    inst_i = NOP;
    @(negedge clk);
    chk("d_rmst_addr", {20'h0, waddr_o}, 32'h300);
    chk("d_rmst_data", data_o, 32'h88);
    tick(); @(negedge clk);
    chk("d_ret_flag", {24'h0, int_flag_o}, 32'hff);
    chk("d_ret_addr", int_addr_o, 32'h104);
    tick(); @(negedge clk);
    chk("d_ret_done", {24'h0, int_flag_o}, 32'h0);
    quiet();

    inst_i = INST_MRET; int_i = INT_TIMER0; global_int_en_i = 1;
    csr_mstatus_i = 32'h80; inst_addr_i = 32'h300;
    tick();
    inst_i = NOP; global_int_en_i = 0;
    @(negedge clk);
    chk("d_both_first", {20'h0, waddr_o}, 32'h300);
    tick();
    global_int_en_i = 1;
    @(negedge clk);
    chk("d_both_ret", {24'h0, int_flag_o}, 32'hff);
    tick(); @(negedge clk);
    chk("d_both_idle", {31'h0, hold_flag_o}, 32'h0);
    tick();
    int_i = INT_NONE;
    @(negedge clk);
    chk("d_both_take", {20'h0, waddr_o}, 32'h341);
    chk("d_both_mepc", data_o, 32'h300);
    quiet();

    hold_flag_i = HOLD_PC; int_i = INT_TIMER0; global_int_en_i = 1;
    tick();
    int_i = INT_NONE;
    @(negedge clk);
    chk("d_hold_block", {31'h0, hold_flag_o}, 32'h0);
    tick(); tick();
    hold_flag_i = HOLD_NONE;
    tick(); @(negedge clk);
`ifdef IRQ_PENDING_LATCH_EN
    exp_we = 32'h1;
`else
    exp_we = 32'h0;
`endif
    chk("d_hold_pulse", {31'h0, we_o}, exp_we);
    quiet();

    int_i = INT_TIMER0; global_int_en_i = 1;
    tick();
    int_i = INT_NONE;
    tick(); @(negedge clk);
    chk("d_rst_in_mcause", {20'h0, waddr_o}, 32'h342);
    #1 rst = 0;
    #1;
    chk("d_rst_we", {31'h0, we_o}, 32'h0);
    chk("d_rst_data", data_o, 32'h0);
    chk("d_rst_hold", {31'h0, hold_flag_o}, 32'h0);
    tick();
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d_no_timer", {24'h0, int_flag_o}, 32'h0);
      tick();
    end
    quiet();

    for (int i = 0; i < 400; i++) begin
      if (!rst) rst = 1;
      else if ($urandom_range(0, 99) == 0) rst = 0;
      inst_i = ($urandom_range(0, 9) == 0) ? INST_MRET : $urandom;
      int_i = ($urandom_range(0, 3) == 0) ? INT_TIMER0 :
              ($urandom_range(0, 5) == 0) ? 8'h02 : INT_NONE;
      hold_flag_i = ($urandom_range(0, 3) == 0) ?
                    HOLD_W'($urandom_range(1, 3)) : HOLD_NONE;
      global_int_en_i = ($urandom_range(0, 4) != 0);
      jump_flag_i = 1'($urandom);
      jump_addr_i = $urandom; inst_addr_i = $urandom;
      csr_mstatus_i = $urandom; csr_mepc_i = $urandom;
      tick();
    end
    rst = 1;
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL: Clock and reset are fixed as one clock; reset is asynchronous and active-low.
REQ-002 SHALL: clk  in  1  core clock; all state updates on its rising edge.
REQ-003 SHALL: rst  in  1  asynchronous, active-low reset (`RstEnable` = 0).
REQ-004 SHALL: inst_i  in  32  instruction currently in execute.
REQ-005 SHALL: inst_addr_i  in  32  PC of inst_i.
REQ-006 SHALL: jump_flag_i / jump_addr_i  in  1/32  execute-stage jump request and target.
REQ-007 SHALL: hold_flag_i  in  `Hold_Flag_Bus`  current pipeline hold level from the hold/jump controller.
REQ-008 SHALL: int_i  in  `INT_BUS`  peripheral interrupt request; `INT_TIMER0` = timer.
REQ-009 SHALL: csr_mstatus_i / csr_mepc_i  in  32/32  current CSR values.
REQ-010 SHALL: global_int_en_i  in  1  mstatus.MIE (bit 3) qualified by the CSR unit.
REQ-011 SHALL: we_o / waddr_o / data_o  out  1/12/32  CSR write port.
REQ-012 SHALL: int_flag_o  out  `INT_BUS`  `INT_NONE`, `INT_TIMER0` or `INT_RET` to the hold/jump controller.
REQ-013 SHALL: int_addr_o  out  32  return address (mepc) driven with `INT_RET`.
REQ-014 SHALL: hold_flag_o  out  1  hold request to the controller while a sequence runs.

Function
REQ-015 SHALL: FSM states are IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, INT_ASSERT, R_MSTATUS, RET_ASSERT.
REQ-016 SHALL: In IDLE, inst_i == 32'h30200073 (mret) -> R_MSTATUS; this has priority over a pending interrupt.
REQ-017 SHALL: In IDLE, pending timer interrupt, global_int_en_i=1 and hold_flag_i == `Hold_None` -> W_MEPC, capturing the return address as jump_addr_i if jump_flag_i=1, else inst_addr_i.
REQ-018 SHALL: W_MEPC: we_o=1, waddr_o=`CSR_MEPC`, data_o=captured address.
REQ-019 SHALL: W_MCAUSE: we_o=1, waddr_o=`CSR_MCAUSE`, data_o=32'h80000007.
REQ-020 SHALL: W_MSTATUS: we_o=1, waddr_o=`CSR_MSTATUS`, data_o=csr_mstatus_i with bit7=bit3 and bit3=0.
REQ-021 SHALL: INT_ASSERT: int_flag_o=`INT_TIMER0` for exactly one cycle, clear the pending flag, then return to IDLE.
REQ-022 SHALL: R_MSTATUS: we_o=1, waddr_o=`CSR_MSTATUS`, data_o=csr_mstatus_i with bit3=bit7 and bit7=1.
REQ-023 SHALL: RET_ASSERT: int_flag_o=`INT_RET` and int_addr_o=csr_mepc_i for exactly one cycle, then return to IDLE.
REQ-024 SHALL: Latency from interrupt acceptance edge to `INT_TIMER0` is 4 cycles; from mret detection to `INT_RET` it is 2 cycles.
REQ-025 SHALL: hold_flag_o=1 in every non-IDLE state; otherwise 0.
REQ-026 SHALL: In IDLE and in states where they are unused, we_o=0, waddr_o=0, data_o=0, int_flag_o=`INT_NONE` and int_addr_o=0.
REQ-027 SHALL: An interrupt that arrives during an mret sequence is taken only after return to IDLE, once MIE has been restored.

Reset
REQ-028 SHALL: rst=0 asynchronously forces IDLE, clears pending and the captured address, and zeroes all outputs, including mid-sequence.

Configuration
REQ-029 SHALL: `IRQ_PENDING_LATCH_EN` defined -> a one-cycle int_i pulse sets a pending bit held until INT_ASSERT; undefined -> pending is the live int_i level (the request is lost if it drops before acceptance).

Structure
REQ-030 SHALL: State encodings, `INT_*` codes, `CSR_MEPC`/`CSR_MCAUSE`/`CSR_MSTATUS` addresses and the mcause value live in the shared defines file.
REQ-031 SHALL: The block is a single module with no sub-module.

Verification
REQ-032 SHALL: The bench covers these directed scenarios:
- int_i=`INT_TIMER0`, MIE=1, inst_addr_i=0x100, no jump -> mepc=0x100, mcause=0x80000007, mstatus 0x8->0x80 written, `INT_TIMER0` at cycle +4.
- Same as above with jump_flag_i=1, jump_addr_i=0x200 -> mepc=0x200.
- mret with mstatus=0x80, mepc=0x104 -> mstatus write 0x88, then `INT_RET` with int_addr_o=0x104.
- mret and a timer interrupt in the same cycle -> mret sequence completes first; the interrupt is taken afterwards.
- Interrupt while hold_flag_i=`Hold_Pc` -> no acceptance until `Hold_None`; with the macro, a 1-cycle pulse is still taken.
- rst asserted in W_MCAUSE -> immediate IDLE, all outputs 0; no `INT_TIMER0` after release.
